// File: rtl/matmul_seq_ctrl_if.sv
// matmul_seq_ctrl_if: host load/start/result port plus systolic-array drive/return signals.
// slave  : the sequencer's view (takes loads, start and array result; drives status and array controls).
// master : the host/array side (the opposite directions).
interface matmul_seq_ctrl_if;
    logic         ld_en;
    logic         ld_sel;
    logic [3:0]   ld_addr;
    logic [31:0]  ld_data;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] res_flat;
    logic         mm_input_start;
    logic [127:0] mm_inA_flat;
    logic [127:0] mm_inB_flat;
    logic [3:0]   mm_counter;
    logic [127:0] mm_outD_flat;
    logic         mm_output_rdy;
    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, mm_outD_flat, mm_output_rdy,
        output busy, done, err, res_flat, mm_input_start, mm_inA_flat, mm_inB_flat, mm_counter
    );
    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, mm_outD_flat, mm_output_rdy,
        input  busy, done, err, res_flat, mm_input_start, mm_inA_flat, mm_inB_flat, mm_counter
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencer feeding skewed A/B lanes into a 4x4 systolic array and capturing its result.
// clk/rst : clock and asynchronous active-high reset.
// bus     : operand word loads, start, busy/done/err, res_flat, and the mm_* array drive/return signals.
module matmul_seq_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int RDY_TIMEOUT  = 2
) (
    input logic clk,
    input logic rst,
    matmul_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, FIRE, WAIT} state_t;
    state_t state, nxtState;
    logic [7:0] cnt, nxtCnt;
    logic doneNxt, errNxt, capture;
    logic [3:0] counterNxt;
    logic [31:0] aMem [16];
    logic [31:0] bMem [16];
    logic [31:0] laneA [4];
    logic [31:0] laneB [4];

    always_comb begin
        nxtState = state;
        nxtCnt   = cnt;
        doneNxt  = 1'b0;
        errNxt   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE:  if (bus.start) nxtState = CLEAR;
            CLEAR: begin
                nxtState = FEED;
                nxtCnt   = '0;
            end
            FEED: begin
                nxtState = cnt == 8'd6 ? DRAIN : FEED;
                nxtCnt   = cnt == 8'd6 ? '0 : cnt + 8'd1;
            end
            DRAIN: begin
                nxtState = cnt == 8'(DRAIN_CYCLES - 1) ? FIRE : DRAIN;
                nxtCnt   = cnt + 8'd1;
            end
            FIRE: begin
                nxtState = WAIT;
                nxtCnt   = '0;
            end
            WAIT: begin
                capture  = bus.mm_output_rdy;
                doneNxt  = bus.mm_output_rdy;
                errNxt   = !bus.mm_output_rdy && cnt == 8'(RDY_TIMEOUT - 1);
                nxtState = (doneNxt || errNxt) ? IDLE : WAIT;
                nxtCnt   = cnt + 8'd1;
            end
            default: nxtState = IDLE;
        endcase
        counterNxt = nxtState == FEED  ? nxtCnt[3:0] :
                     nxtState == DRAIN ? 4'd6 :
                     nxtState == FIRE  ? 4'd7 : 4'd0;
    end

    // Lane k carries diagonal r = t-k; an out-of-range r wraps to 13..15, so r[3:2]!=0 marks an idle lane.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [3:0] r;
        assign r        = nxtCnt[3:0] - 4'(k);
        assign laneA[k] = (nxtState == FEED && r[3:2] == 2'b00) ? aMem[{r[1:0], 2'(k)}] : '0;
        assign laneB[k] = (nxtState == FEED && r[3:2] == 2'b00) ? bMem[{2'(k), r[1:0]}] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxtState;
            cnt   <= nxtCnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                aMem[i] <= '0;
                bMem[i] <= '0;
            end
        end else if (state == IDLE && bus.ld_en) begin
            if (bus.ld_sel) bMem[bus.ld_addr] <= bus.ld_data;
            else aMem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Every output is registered from the next-state decode so it lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.err            <= 1'b0;
            bus.res_flat       <= '0;
            bus.mm_input_start <= 1'b0;
            bus.mm_counter     <= '0;
            bus.mm_inA_flat    <= '0;
            bus.mm_inB_flat    <= '0;
        end else begin
            bus.busy           <= nxtState != IDLE;
            bus.done           <= doneNxt;
            bus.err            <= errNxt;
            bus.mm_input_start <= nxtState == CLEAR;
            bus.mm_counter     <= counterNxt;
            bus.mm_inA_flat    <= {laneA[0], laneA[1], laneA[2], laneA[3]};
            bus.mm_inB_flat    <= {laneB[0], laneB[1], laneB[2], laneB[3]};
            if (capture) bus.res_flat <= bus.mm_outD_flat;
        end
    end
endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencer for the 4x4 systolic multiply-accumulate array. It holds operand matrices A and B in local register files loaded over a word-write port. On `start` it clears the array, streams skewed operand lanes into it, then drives the array's `counter` to release the result. It captures the 128-bit result and reports `done`/`err` to the host.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: idle-lane cycles after feeding before results are released. Legal range 1..8.
- `RDY_TIMEOUT`, default 2: WAIT cycles allowed for `output_rdy` before `err`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_en`  in  1  write one operand word this cycle.
- `ld_sel`  in  1  0 = matrix A, 1 = matrix B.
- `ld_addr`  in  4  element index = row*4 + col.
- `ld_data`  in  32  element value.
- `start`  in  1  request a multiply.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`/`err`.
- `done`  out  1  one-cycle pulse; `res_flat` is valid.
- `err`  out  1  one-cycle pulse on `output_rdy` timeout.
- `res_flat`  out  128  captured result, lane 0 in [127:96]; holds until the next capture.
- `mm_input_start`  out  1  array accumulator clear.
- `mm_inA_flat`, `mm_inB_flat`  out  128  array operand lanes, lane k in bits [127-32k:96-32k].
- `mm_counter`  out  4  array result-release control.
- `mm_outD_flat`  in  128  array result.
- `mm_output_rdy`  in  1  array result valid.

## Operation
States: IDLE, CLEAR, FEED, DRAIN, FIRE, WAIT.
- IDLE:
  - `start`=1 moves to CLEAR.
  - `ld_en` writes `A[ld_addr]` or `B[ld_addr]`.
  - Writes are ignored in every other state.
  - If `ld_en` and `start` arrive in the same cycle, the write lands first and the run uses the new value.
- CLEAR: 1 cycle. `mm_input_start`=1, lanes 0, `mm_counter`=0.
- FEED: 7 cycles, step t=0..6.
  - A lane j = A[row t-j][col j] when 0 ≤ t-j ≤ 3, else 0.
  - B lane i = B[row i][col t-i] when 0 ≤ t-i ≤ 3, else 0.
  - `mm_counter`=t.
- DRAIN: `DRAIN_CYCLES` cycles. Lanes 0, `mm_counter`=6.
- FIRE: 1 cycle. `mm_counter`=7, lanes 0.
- WAIT:
  - `mm_counter`=0, lanes 0.
  - On the first cycle with `mm_output_rdy`=1: `res_flat` ← `mm_outD_flat`, `done` pulses next cycle, go to IDLE.
  - If `mm_output_rdy` is not seen within `RDY_TIMEOUT` cycles: `err` pulses, `res_flat` is unchanged, go to IDLE.
- `start` while busy is ignored and is not queued.
- `mm_output_rdy` outside WAIT is ignored.
- Operand registers persist across runs. Only loads change them.
- Arithmetic is entirely in the array; this block only moves 32-bit words and does no width change.

## Timing
- Reset value of every output and state register is 0: IDLE, `busy`=0, `done`=0, `err`=0, `res_flat`=0, all `mm_*` outputs 0. The A and B files also reset to 0.
- Reset asserted mid-run aborts immediately: no `done`, no `err`, `mm_input_start` drops asynchronously.
- Start accepted at edge 0:
  - CLEAR is cycle 1, FEED is cycles 2–8, DRAIN is cycles 9..8+`DRAIN_CYCLES`, FIRE is cycle 9+`DRAIN_CYCLES`.
  - `mm_output_rdy` is expected in cycle 10+`DRAIN_CYCLES`.
  - `done` is high in cycle 11+`DRAIN_CYCLES` (15 with defaults).
- `busy` falls in the same cycle `done`/`err` is high.
- A new `start` is accepted in the `done` cycle. Back-to-back runs therefore have a period of 11+`DRAIN_CYCLES` cycles.
- All `mm_*` outputs are registered. Lane values change only on clock edges.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs read 0 before the next edge; a following `start` runs normally.
- Feed skew, A = element value 16+idx, B = 32+idx -> at step t=3:
  - `mm_inA_flat` lanes = {A[3][0], A[2][1], A[1][2], A[0][3]} = {28, 25, 22, 19}.
  - `mm_inB_flat` lanes = {B[0][3], B[1][2], B[2][1], B[3][0]} = {35, 38, 41, 44}.
  - At t=0, only lane 0 is nonzero (16 and 32).
- Full run, A = identity, B = element value idx+1 -> `done` at cycle 15; `res_flat` equals the array's `mm_outD_flat` sampled in cycle 14.
- Timeout: hold `mm_output_rdy`=0 -> `err` pulses at cycle 16, `done` never asserts, `res_flat` keeps its prior value.
- Busy protection: during FEED, issue `ld_en` (A[0]=0xDEAD) and `start` -> A[0] is unchanged, the run completes once, and no second run starts.
- Back-to-back: assert `start` in the `done` cycle -> CLEAR in the next cycle, `mm_input_start`=1, second `done` 15 cycles later.
